// File: rtl/alu_issue_pkg.sv
// Shared types and opcode constants for the ALU issue slice.
// Covers the LoongArch subset decoded ahead of the ALU stage.
package alu_issue_pkg;

  localparam int ALU_W = 12;

  localparam int OP_ADD  = 0;
  localparam int OP_SUB  = 1;
  localparam int OP_SLT  = 2;
  localparam int OP_SLTU = 3;
  localparam int OP_AND  = 4;
  localparam int OP_NOR  = 5;
  localparam int OP_OR   = 6;
  localparam int OP_XOR  = 7;
  localparam int OP_SLL  = 8;
  localparam int OP_SRL  = 9;
  localparam int OP_SRA  = 10;
  localparam int OP_LUI  = 11;

  typedef logic [ALU_W-1:0] alu_op_t;

  localparam logic [5:0] OP31_26_ZERO = 6'h00;

  localparam logic [3:0] OP25_22_3R = 4'h0;
  localparam logic [3:0] OP25_22_SH = 4'h1;
  localparam logic [1:0] OP21_20_3R = 2'b01;
  localparam logic [1:0] OP21_20_SH = 2'b00;

  localparam logic [4:0] F3R_ADD  = 5'h00;
  localparam logic [4:0] F3R_SUB  = 5'h02;
  localparam logic [4:0] F3R_SLT  = 5'h04;
  localparam logic [4:0] F3R_SLTU = 5'h05;
  localparam logic [4:0] F3R_NOR  = 5'h08;
  localparam logic [4:0] F3R_AND  = 5'h09;
  localparam logic [4:0] F3R_OR   = 5'h0A;
  localparam logic [4:0] F3R_XOR  = 5'h0B;
  localparam logic [4:0] F3R_SLL  = 5'h0E;
  localparam logic [4:0] F3R_SRL  = 5'h0F;
  localparam logic [4:0] F3R_SRA  = 5'h10;

  localparam logic [4:0] FSH_SLL = 5'h01;
  localparam logic [4:0] FSH_SRL = 5'h09;
  localparam logic [4:0] FSH_SRA = 5'h11;

  localparam logic [3:0] RI_SLT  = 4'h8;
  localparam logic [3:0] RI_SLTU = 4'h9;
  localparam logic [3:0] RI_ADD  = 4'hA;
  localparam logic [3:0] RI_AND  = 4'hD;
  localparam logic [3:0] RI_OR   = 4'hE;
  localparam logic [3:0] RI_XOR  = 4'hF;

  localparam logic [6:0] OP_LU12I     = 7'h0A;
  localparam logic [6:0] OP_PCADDU12I = 7'h0E;

  typedef enum logic [1:0] {
    EMPTY,
    ONE,
    FULL
  } state_t;

  typedef struct packed {
    alu_op_t     op;
    logic [31:0] src1;
    logic [31:0] src2;
    logic [4:0]  dest;
    logic        gr_we;
    logic        illegal;
  } uop_t;

  function automatic alu_op_t onehot(input int idx);
    return alu_op_t'(1) << idx;
  endfunction

  function automatic logic [31:0] sext12(input logic [11:0] v);
    return {{20{v[11]}}, v};
  endfunction

  function automatic logic [31:0] zext12(input logic [11:0] v);
    return {20'b0, v};
  endfunction

  function automatic logic [31:0] zext5(input logic [4:0] v);
    return {27'b0, v};
  endfunction

  function automatic logic [31:0] upper20(input logic [19:0] v);
    return {v, 12'b0};
  endfunction

endpackage

// File: rtl/alu_issue_dec.sv
// Combinational decoder: instruction word plus operands
// to a one-hot ALU op, operand pair and writeback control.
module alu_issue_dec
  import alu_issue_pkg::*;
(
  input  logic [31:0] inst,
  input  logic [31:0] pc,
  input  logic [31:0] rj,
  input  logic [31:0] rkd,
  output logic [11:0] alu_op,
  output logic [31:0] src1,
  output logic [31:0] src2,
  output logic [4:0]  dest,
  output logic        gr_we,
  output logic        illegal
);

  logic [5:0]  op31_26;
  logic [3:0]  op25_22;
  logic [1:0]  op21_20;
  logic [4:0]  op19_15;
  logic [6:0]  op31_25;

  logic        is_3r;
  logic        is_sh;
  logic        is_ri;
  logic        is_lu;
  logic        is_pca;

  alu_op_t     op;
  logic [31:0] s1;
  logic [31:0] s2;

  // rj index bits are resolved by the register file, not here
  logic        unused_rj_idx;
  assign unused_rj_idx = ^inst[9:5];

  assign op31_26 = inst[31:26];
  assign op25_22 = inst[25:22];
  assign op21_20 = inst[21:20];
  assign op19_15 = inst[19:15];
  assign op31_25 = inst[31:25];

  assign is_3r = (op31_26 == OP31_26_ZERO)
              && (op25_22 == OP25_22_3R)
              && (op21_20 == OP21_20_3R);
  assign is_sh = (op31_26 == OP31_26_ZERO)
              && (op25_22 == OP25_22_SH)
              && (op21_20 == OP21_20_SH);
  // every 2RI12 ALU form has op25_22[3] set
  assign is_ri = (op31_26 == OP31_26_ZERO)
              && op25_22[3];
  assign is_lu  = (op31_25 == OP_LU12I);
  assign is_pca = (op31_25 == OP_PCADDU12I);

  // select op and raw operands per instruction class
  always_comb begin
    op = '0;
    s1 = '0;
    s2 = '0;
    unique case (1'b1)
      is_3r: begin
        s1 = rj;
        s2 = rkd;
        case (op19_15)
          F3R_ADD:  op = onehot(OP_ADD);
          F3R_SUB:  op = onehot(OP_SUB);
          F3R_SLT:  op = onehot(OP_SLT);
          F3R_SLTU: op = onehot(OP_SLTU);
          F3R_NOR:  op = onehot(OP_NOR);
          F3R_AND:  op = onehot(OP_AND);
          F3R_OR:   op = onehot(OP_OR);
          F3R_XOR:  op = onehot(OP_XOR);
          F3R_SLL:  op = onehot(OP_SLL);
          F3R_SRL:  op = onehot(OP_SRL);
          F3R_SRA:  op = onehot(OP_SRA);
          default:  op = '0;
        endcase
      end
      is_sh: begin
        s1 = rj;
        s2 = zext5(inst[14:10]);
        case (op19_15)
          FSH_SLL: op = onehot(OP_SLL);
          FSH_SRL: op = onehot(OP_SRL);
          FSH_SRA: op = onehot(OP_SRA);
          default: op = '0;
        endcase
      end
      is_ri: begin
        s1 = rj;
        s2 = sext12(inst[21:10]);
        case (op25_22)
          RI_SLT:  op = onehot(OP_SLT);
          RI_SLTU: op = onehot(OP_SLTU);
          RI_ADD:  op = onehot(OP_ADD);
          RI_AND: begin
            op = onehot(OP_AND);
            s2 = zext12(inst[21:10]);
          end
          RI_OR: begin
            op = onehot(OP_OR);
            s2 = zext12(inst[21:10]);
          end
          RI_XOR: begin
            op = onehot(OP_XOR);
            s2 = zext12(inst[21:10]);
          end
          default: op = '0;
        endcase
      end
      is_lu: begin
        op = onehot(OP_LUI);
        s2 = upper20(inst[24:5]);
      end
      is_pca: begin
        op = onehot(OP_ADD);
        s1 = pc;
        s2 = upper20(inst[24:5]);
      end
      default: op = '0;
    endcase
  end

  // unsupported words carry no op, no operands and no write
  assign illegal = ~|op;
  assign alu_op  = op;
  assign src1    = illegal ? '0 : s1;
  assign src2    = illegal ? '0 : s2;
  assign dest    = inst[4:0];
  assign gr_we   = !illegal && (inst[4:0] != 5'd0);

endmodule

// File: rtl/alu_issue.sv
// Issue stage: decodes a bundle and holds it in a
// main + skid buffer behind a valid/ready handshake.
module alu_issue
  import alu_issue_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_inst,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_rj,
  input  logic [31:0] in_rkd,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [11:0] alu_op,
  output logic [31:0] alu_src1,
  output logic [31:0] alu_src2,
  output logic [4:0]  dest,
  output logic        gr_we,
  output logic        illegal
);

  if (DEPTH != 2) begin : g_depth_check
    $error("alu_issue: DEPTH must be 2");
  end

  logic [11:0] d_op;
  logic [31:0] d_src1;
  logic [31:0] d_src2;
  logic [4:0]  d_dest;
  logic        d_we;
  logic        d_ill;

  uop_t   dec;
  uop_t   head;
  uop_t   skid;
  state_t state;

  logic   accept;
  logic   drain;

  alu_issue_dec u_dec (
    .inst    (in_inst),
    .pc      (in_pc),
    .rj      (in_rj),
    .rkd     (in_rkd),
    .alu_op  (d_op),
    .src1    (d_src1),
    .src2    (d_src2),
    .dest    (d_dest),
    .gr_we   (d_we),
    .illegal (d_ill)
  );

  // pack decoder results into one entry
  always_comb begin
    dec         = '0;
    dec.op      = d_op;
    dec.src1    = d_src1;
    dec.src2    = d_src2;
    dec.dest    = d_dest;
    dec.gr_we   = d_we;
    dec.illegal = d_ill;
  end

  assign accept = in_valid & in_ready;
  assign drain  = out_valid & out_ready;

  // buffer FSM; head drives the outputs, skid catches
  // the one bundle accepted while the head is stalled
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= EMPTY;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      head      <= '0;
      skid      <= '0;
    end else begin
      unique case (state)
        EMPTY: begin
          if (accept) begin
            head      <= dec;
            out_valid <= 1'b1;
            state     <= ONE;
          end
        end
        ONE: begin
          if (accept && drain) begin
            head <= dec;
          end else if (accept) begin
            skid     <= dec;
            in_ready <= 1'b0;
            state    <= FULL;
          end else if (drain) begin
            out_valid <= 1'b0;
            state     <= EMPTY;
          end
        end
        FULL: begin
          if (drain) begin
            head     <= skid;
            in_ready <= 1'b1;
            state    <= ONE;
          end
        end
        default: begin
          state     <= EMPTY;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

  assign alu_op   = head.op;
  assign alu_src1 = head.src1;
  assign alu_src2 = head.src2;
  assign dest     = head.dest;
  assign gr_we    = head.gr_we;
  assign illegal  = head.illegal;

endmodule

// File: tb/tb_alu_issue.sv
// Bench for alu_issue: directed vectors, stall/reset
// sequences and a random run against a queue model.
module tb_alu_issue;

  typedef struct packed {
    logic [11:0] op;
    logic [31:0] s1;
    logic [31:0] s2;
    logic [4:0]  dest;
    logic        we;
    logic        ill;
  } exp_t;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] rj;
    logic [31:0] rk;
    exp_t        e;
  } vec_t;

  localparam int ADD = 0, SUB = 1, SLT = 2, SLTU = 3;
  localparam int AND = 4, NOR = 5, OR = 6, XOR = 7;
  localparam int SLL = 8, SRL = 9, SRA = 10, LUI = 11;
  localparam int NV = 11;

  logic        clk = 1'b0;
  logic        resetn;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_inst;
  logic [31:0] in_pc;
  logic [31:0] in_rj;
  logic [31:0] in_rkd;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] alu_op;
  logic [31:0] alu_src1;
  logic [31:0] alu_src2;
  logic [4:0]  dest;
  logic        gr_we;
  logic        illegal;

  int   total = 0;
  int   passed = 0;
  int   ndrain = 0;
  exp_t q[$];
  vec_t vecs[NV];

  logic [4:0] f3r_list[11] = '{5'h00, 5'h02, 5'h04,
    5'h05, 5'h08, 5'h09, 5'h0A, 5'h0B, 5'h0E,
    5'h0F, 5'h10};
  logic [4:0] fsh_list[3] = '{5'h01, 5'h09, 5'h11};

  always #5 clk = ~clk;

  alu_issue #(.DEPTH(2)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_inst   (in_inst),
    .in_pc     (in_pc),
    .in_rj     (in_rj),
    .in_rkd    (in_rkd),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .alu_op    (alu_op),
    .alu_src1  (alu_src1),
    .alu_src2  (alu_src2),
    .dest      (dest),
    .gr_we     (gr_we),
    .illegal   (illegal)
  );

  task automatic chk_bit(input string n,
                         input logic a, input logic e);
    total++;
    if (a === e) passed++;
    else $display("FAIL %s: got %0b want %0b", n, a, e);
  endtask

  task automatic chk_val(input string n,
                         input logic [31:0] a,
                         input logic [31:0] e);
    total++;
    if (a === e) passed++;
    else $display("FAIL %s: got %0d want %0d", n, a, e);
  endtask

  task automatic chk_uop(input string n,
                         input exp_t a, input exp_t e);
    total++;
    if (a === e) passed++;
    else $display("FAIL %s: got %h want %h", n, a, e);
  endtask

  function automatic exp_t got();
    exp_t g;
    g.op   = alu_op;
    g.s1   = alu_src1;
    g.s2   = alu_src2;
    g.dest = dest;
    g.we   = gr_we;
    g.ill  = illegal;
    return g;
  endfunction

  // reference: match whole instruction patterns by mnemonic
  function automatic exp_t model(input logic [31:0] i,
                                 input logic [31:0] pc,
                                 input logic [31:0] rj,
                                 input logic [31:0] rk);
    exp_t e;
    int k;
    logic [31:0] a, b;
    k = -1;
    a = rj;
    b = rk;
    if (i[31:20] == 12'h001) begin
      case (i[19:15])
        5'h00: k = ADD;
        5'h02: k = SUB;
        5'h04: k = SLT;
        5'h05: k = SLTU;
        5'h08: k = NOR;
        5'h09: k = AND;
        5'h0A: k = OR;
        5'h0B: k = XOR;
        5'h0E: k = SLL;
        5'h0F: k = SRL;
        5'h10: k = SRA;
        default: k = -1;
      endcase
    end else if (i[31:20] == 12'h004) begin
      b = {27'b0, i[14:10]};
      case (i[19:15])
        5'h01: k = SLL;
        5'h09: k = SRL;
        5'h11: k = SRA;
        default: k = -1;
      endcase
    end else if (i[31:26] == 6'd0) begin
      b = {{20{i[21]}}, i[21:10]};
      case (i[25:22])
        4'h8: k = SLT;
        4'h9: k = SLTU;
        4'hA: k = ADD;
        4'hD: k = AND;
        4'hE: k = OR;
        4'hF: k = XOR;
        default: k = -1;
      endcase
      if (k == AND || k == OR || k == XOR)
        b = {20'b0, i[21:10]};
    end else if (i[31:25] == 7'h0A) begin
      k = LUI;
      a = 32'd0;
      b = {i[24:5], 12'b0};
    end else if (i[31:25] == 7'h0E) begin
      k = ADD;
      a = pc;
      b = {i[24:5], 12'b0};
    end
    e.dest = i[4:0];
    e.ill  = (k < 0);
    e.op   = (k < 0) ? 12'h0 : (12'h1 << k);
    e.s1   = (k < 0) ? 32'd0 : a;
    e.s2   = (k < 0) ? 32'd0 : b;
    e.we   = (k >= 0) && (i[4:0] != 5'd0);
    return e;
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 5))
      0: r[31:15] = {12'h001,
                     f3r_list[$urandom_range(0, 10)]};
      1: r[31:15] = {12'h001, 5'($urandom)};
      2: r[31:15] = {12'h004,
                     fsh_list[$urandom_range(0, 2)]};
      3: r[31:22] = {6'd0, 4'($urandom_range(8, 15))};
      4: r[31:25] = ($urandom_range(0, 1) == 0)
                    ? 7'h0A : 7'h0E;
      default: r = r;
    endcase
    return r;
  endfunction

  function automatic vec_t mk(
    input logic [31:0] inst, input logic [31:0] pc,
    input logic [31:0] rj, input logic [31:0] rk,
    input logic [11:0] op, input logic [31:0] s1,
    input logic [31:0] s2, input logic [4:0] d,
    input logic we, input logic ill);
    vec_t v;
    v.inst = inst;
    v.pc = pc;
    v.rj = rj;
    v.rk = rk;
    v.e.op = op;
    v.e.s1 = s1;
    v.e.s2 = s2;
    v.e.dest = d;
    v.e.we = we;
    v.e.ill = ill;
    return v;
  endfunction

  task automatic drive(input logic v, input vec_t x,
                       input logic rdy);
    in_valid  = v;
    in_inst   = x.inst;
    in_pc     = x.pc;
    in_rj     = x.rj;
    in_rkd    = x.rk;
    out_ready = rdy;
  endtask

  // one cycle: check against model, drive, update model
  task automatic step(input logic v, input vec_t x,
                      input logic rdy);
    int n;
    n = q.size();
    chk_bit("rnd out_valid", out_valid, n > 0);
    chk_bit("rnd in_ready", in_ready, n < 2);
    if (n > 0) chk_uop("rnd payload", got(), q[0]);
    if (out_valid && rdy) ndrain++;
    drive(v, x, rdy);
    @(posedge clk);
    if (n > 0 && rdy) void'(q.pop_front());
    if (v && n < 2) q.push_back(model(x.inst, x.pc, x.rj, x.rk));
    @(negedge clk);
  endtask

  function automatic vec_t rnd_vec();
    vec_t x;
    x = '0;
    x.inst = rand_inst();
    x.pc = $urandom;
    x.rj = $urandom;
    x.rk = $urandom;
    return x;
  endfunction

  initial begin
    exp_t zero_e;
    vec_t idle;
    zero_e = '0;
    idle = '0;

    vecs[0] = mk(32'h00100823, 32'h0, 32'd5, 32'd7,
      12'h001, 32'd5, 32'd7, 5'd3, 1'b1, 1'b0);
    vecs[1] = mk(32'h02BFFC24, 32'h0, 32'd1, 32'hDEAD,
      12'h001, 32'd1, 32'hFFFFFFFF, 5'd4, 1'b1, 1'b0);
    vecs[2] = mk(32'h03BFFC24, 32'h0, 32'h1234, 32'h0,
      12'h040, 32'h1234, 32'h00000FFF, 5'd4, 1'b1, 1'b0);
    vecs[3] = mk(32'h1C000025, 32'h1C000000, 32'h55, 32'h0,
      12'h001, 32'h1C000000, 32'h1000, 5'd5, 1'b1, 1'b0);
    vecs[4] = mk(32'h14000025, 32'h1C000000, 32'h55, 32'h0,
      12'h800, 32'h0, 32'h1000, 5'd5, 1'b1, 1'b0);
    vecs[5] = mk(32'hFFFFFFFF, 32'h40, 32'd9, 32'd9,
      12'h000, 32'h0, 32'h0, 5'd31, 1'b0, 1'b1);
    vecs[6] = mk(32'h0048FC46, 32'h0, 32'h80000000, 32'd1,
      12'h400, 32'h80000000, 32'd31, 5'd6, 1'b1, 1'b0);
    vecs[7] = mk(32'h00100820, 32'h0, 32'd5, 32'd7,
      12'h001, 32'd5, 32'd7, 5'd0, 1'b0, 1'b0);
    vecs[8] = mk(32'h00110823, 32'h0, 32'd10, 32'd3,
      12'h002, 32'd10, 32'd3, 5'd3, 1'b1, 1'b0);
    vecs[9] = mk(32'h03600027, 32'h0, 32'hF0F0, 32'h0,
      12'h010, 32'hF0F0, 32'h800, 5'd7, 1'b1, 1'b0);
    vecs[10] = mk(32'h02200027, 32'h0, 32'h77, 32'h0,
      12'h004, 32'h77, 32'hFFFFF800, 5'd7, 1'b1, 1'b0);

    resetn = 1'b1;
    drive(1'b0, idle, 1'b0);
    #2 resetn = 1'b0;
    #1;
    chk_bit("rst out_valid", out_valid, 1'b0);
    chk_bit("rst in_ready", in_ready, 1'b1);
    chk_uop("rst payload", got(), zero_e);
    @(negedge clk);
    @(negedge clk);
    chk_bit("rst hold out_valid", out_valid, 1'b0);
    resetn = 1'b1;
    @(negedge clk);

    // directed single transfers with one-cycle latency
    for (int n = 0; n < NV; n++) begin
      drive(1'b1, vecs[n], 1'b1);
      @(negedge clk);
      drive(1'b0, idle, 1'b1);
      chk_bit($sformatf("vec%0d out_valid", n),
              out_valid, 1'b1);
      chk_uop($sformatf("vec%0d payload", n),
              got(), vecs[n].e);
      @(negedge clk);
    end
    chk_bit("drained out_valid", out_valid, 1'b0);

    // stall three cycles with a steady input stream
    drive(1'b1, vecs[0], 1'b0);
    @(negedge clk);
    chk_bit("stall c1 out_valid", out_valid, 1'b1);
    chk_bit("stall c1 in_ready", in_ready, 1'b1);
    chk_uop("stall c1 payload", got(), vecs[0].e);
    drive(1'b1, vecs[8], 1'b0);
    @(negedge clk);
    chk_bit("stall c2 in_ready", in_ready, 1'b0);
    chk_uop("stall c2 payload", got(), vecs[0].e);
    drive(1'b1, vecs[2], 1'b0);
    @(negedge clk);
    chk_bit("stall c3 in_ready", in_ready, 1'b0);
    chk_bit("stall c3 out_valid", out_valid, 1'b1);
    chk_uop("stall c3 payload", got(), vecs[0].e);
    drive(1'b0, idle, 1'b1);
    @(negedge clk);
    chk_bit("release out_valid", out_valid, 1'b1);
    chk_bit("release in_ready", in_ready, 1'b1);
    chk_uop("release second", got(), vecs[8].e);
    @(negedge clk);
    chk_bit("release empty", out_valid, 1'b0);

    // reset while both entries are occupied
    drive(1'b1, vecs[1], 1'b0);
    @(negedge clk);
    drive(1'b1, vecs[6], 1'b0);
    @(negedge clk);
    chk_bit("full in_ready", in_ready, 1'b0);
    drive(1'b0, idle, 1'b0);
    resetn = 1'b0;
    #1;
    chk_bit("full rst out_valid", out_valid, 1'b0);
    chk_bit("full rst in_ready", in_ready, 1'b1);
    chk_uop("full rst payload", got(), zero_e);
    @(negedge clk);
    resetn = 1'b1;
    drive(1'b1, vecs[3], 1'b1);
    #1;
    chk_bit("post rst no stale", out_valid, 1'b0);
    @(negedge clk);
    drive(1'b0, idle, 1'b1);
    chk_bit("post rst out_valid", out_valid, 1'b1);
    chk_uop("post rst payload", got(), vecs[3].e);
    @(negedge clk);
    chk_bit("post rst drained", out_valid, 1'b0);

    // back-to-back stream: one op per cycle
    q.delete();
    ndrain = 0;
    for (int n = 0; n < 20; n++)
      step(1'b1, rnd_vec(), 1'b1);
    chk_val("throughput drains", ndrain, 32'd19);

    // random handshake traffic
    for (int n = 0; n < 2000; n++)
      step($urandom_range(0, 3) != 0, rnd_vec(),
           $urandom_range(0, 2) != 0);
    for (int n = 0; n < 3; n++)
      step(1'b0, idle, 1'b1);
    chk_val("final occupancy", q.size(), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
